// File: rtl/d8_fetch_seq_if.sv
// Bundle of the dumb8 fetch sequencer's memory, execute, jump and status signals.
// The master side is the sequencer; the slave side is its environment.
interface d8_fetch_seq_if;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] op;
    logic [7:0] arg;
    logic       exec;
    logic       exec_done;
    logic       jmp_load;
    logic [7:0] jmp_addr;
    logic [7:0] pc;
    logic       halted;

    modport master (
        input  run,
        input  imem_ack,
        input  imem_data,
        input  exec_done,
        input  jmp_load,
        input  jmp_addr,
        output imem_req,
        output imem_addr,
        output op,
        output arg,
        output exec,
        output pc,
        output halted
    );

    modport slave (
        output run,
        output imem_ack,
        output imem_data,
        output exec_done,
        output jmp_load,
        output jmp_addr,
        input  imem_req,
        input  imem_addr,
        input  op,
        input  arg,
        input  exec,
        input  pc,
        input  halted
    );
endinterface

// File: rtl/d8_fetch_seq.sv
// dumb8 instruction fetch/execute sequencer: owns the PC, fetches opcode and operand
// bytes over req/ack, hands them to the execute unit and advances or jumps on completion.
module d8_fetch_seq #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] HALT_OP  = 8'hff
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    d8_fetch_seq_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFOp,
        StFArg,
        StExec,
        StHalt
    } state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] w_pc_nxt;
    logic [7:0] r_op;
    logic [7:0] w_op_nxt;
    logic [7:0] r_arg;
    logic [7:0] w_arg_nxt;
    logic       r_exec;
    logic       w_exec_nxt;

    logic [7:0] w_pc_inc1;
    logic [7:0] w_pc_inc2;

    assign w_pc_inc1 = r_pc + 8'd1;
    assign w_pc_inc2 = r_pc + 8'd2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
            r_op    <= 8'h00;
            r_arg   <= 8'h00;
            r_exec  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_op    <= w_op_nxt;
            r_arg   <= w_arg_nxt;
            r_exec  <= w_exec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_op_nxt    = r_op;
        w_arg_nxt   = r_arg;
        w_exec_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.run) begin
                    w_state_nxt = StFOp;
                end
            end
            StFOp: begin
                if (bus.imem_ack) begin
                    w_op_nxt    = bus.imem_data;
                    w_state_nxt = StFArg;
                end
            end
            StFArg: begin
                if (bus.imem_ack) begin
                    w_arg_nxt = bus.imem_data;
                    if (r_op == HALT_OP) begin
                        w_state_nxt = StHalt;
                    end else begin
                        w_state_nxt = StExec;
                        // exec is a registered pulse for the first EXEC cycle only
                        w_exec_nxt  = 1'b1;
                    end
                end
            end
            StExec: begin
                if (bus.exec_done) begin
                    w_pc_nxt    = bus.jmp_load ? bus.jmp_addr : w_pc_inc2;
                    w_state_nxt = StFOp;
                end
            end
            StHalt: begin
                if (bus.run) begin
                    w_pc_nxt    = w_pc_inc2;
                    w_state_nxt = StFOp;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign bus.imem_req  = (r_state == StFOp) || (r_state == StFArg);
    assign bus.imem_addr = (r_state == StFArg) ? w_pc_inc1 : r_pc;
    assign bus.exec      = r_exec;
    assign bus.op        = r_op;
    assign bus.arg       = r_arg;
    assign bus.pc        = r_pc;
    assign bus.halted    = (r_state == StHalt);

endmodule

// File: tb/tb_d8_fetch_seq.sv
// Directed bench for d8_fetch_seq: memory and execute-unit responders plus a linear
// sequence of program phases, each checked with immediate assertions.
module tb_d8_fetch_seq;

    logic clk;
    logic rst_n;

    d8_fetch_seq_if bus ();

    d8_fetch_seq dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] mem [256];
    int         wait_cycles = 0;
    int         wcnt        = 0;
    logic       ack_r       = 1'b0;
    logic [7:0] data_r      = 8'h00;
    logic       ack_force   = 1'b0;
    logic       pend        = 1'b0;
    logic [7:0] pend_addr   = 8'h00;
    int         unstable    = 0;
    logic [7:0] addr_log [$];

    logic done_always = 1'b1;
    int   done_delay  = 0;
    logic done_r      = 1'b0;
    logic busy        = 1'b0;
    int   ecnt        = 0;

    int         exec_cyc [$];
    logic [7:0] exec_op  [$];
    logic [7:0] exec_arg [$];
    logic       exec_prev = 1'b0;
    int         exec_dbl  = 0;

    assign bus.imem_ack  = ack_r | ack_force;
    assign bus.imem_data = ack_force ? 8'hab : data_r;
    assign bus.exec_done = done_always | done_r;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: acks after wait_cycles idle cycles, logs accepted addresses and
    // flags any address change while a request is still pending.
    always @(negedge clk) begin
        if (bus.imem_req === 1'b1) begin
            if (pend && (bus.imem_addr !== pend_addr)) unstable <= unstable + 1;
            if (wcnt >= wait_cycles) begin
                ack_r  <= 1'b1;
                data_r <= mem[bus.imem_addr];
                wcnt   <= 0;
                pend   <= 1'b0;
                addr_log.push_back(bus.imem_addr);
            end else begin
                ack_r     <= 1'b0;
                wcnt      <= wcnt + 1;
                pend      <= 1'b1;
                pend_addr <= bus.imem_addr;
            end
        end else begin
            ack_r <= 1'b0;
            wcnt  <= 0;
            pend  <= 1'b0;
        end
    end

    // Execute unit: raises exec_done done_delay cycles after the exec pulse.
    always @(negedge clk) begin
        if (bus.exec === 1'b1) begin
            done_r <= (done_delay == 0);
            busy   <= (done_delay != 0);
            ecnt   <= 0;
        end else if (busy) begin
            done_r <= (ecnt + 1 == done_delay);
            if (ecnt + 1 == done_delay) busy <= 1'b0;
            ecnt <= ecnt + 1;
        end else begin
            done_r <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.exec === 1'b1) begin
            exec_cyc.push_back(cyc);
            exec_op.push_back(bus.op);
            exec_arg.push_back(bus.arg);
        end
        if (exec_prev && (bus.exec === 1'b1)) exec_dbl <= exec_dbl + 1;
        exec_prev <= (bus.exec === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pulse();
        bus.run = 1'b1;
        step();
        bus.run = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while ((bus.halted !== 1'b1) && (n < 200)) begin
            step();
            n++;
        end
        chk(tag, {31'd0, bus.halted}, 32'd1);
    endtask

    task automatic wait_exec(input string tag);
        int n = 0;
        while ((bus.exec !== 1'b1) && (n < 200)) begin
            step();
            n++;
        end
        chk(tag, {31'd0, bus.exec}, 32'd1);
    endtask

    task automatic clear_logs();
        addr_log.delete();
        exec_cyc.delete();
        exec_op.delete();
        exec_arg.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h01; mem[8'h01] = 8'h11; mem[8'h02] = 8'h02; mem[8'h03] = 8'h22;
        mem[8'h04] = 8'hff; mem[8'h06] = 8'h03; mem[8'h07] = 8'h33; mem[8'h08] = 8'h04;
        mem[8'h09] = 8'h44; mem[8'h0a] = 8'hff; mem[8'h0c] = 8'h09; mem[8'h40] = 8'hff;
        mem[8'h42] = 8'h09; mem[8'h44] = 8'hff; mem[8'h46] = 8'h05; mem[8'h47] = 8'h55;
        mem[8'h48] = 8'hff; mem[8'h4a] = 8'h09; mem[8'hfe] = 8'h06; mem[8'hff] = 8'h66;
        bus.run      = 1'b0;
        bus.jmp_load = 1'b0;
        bus.jmp_addr = 8'h00;
        rst_n        = 1'b0;
        #3;
        chk("rst_pc", bus.pc, 32'h00);
        chk("rst_addr", bus.imem_addr, 32'h00);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_op", bus.op, 32'h00);
        chk("rst_arg", bus.arg, 32'h00);
        chk("rst_exec", {31'd0, bus.exec}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_req", {31'd0, bus.imem_req}, 32'd0);

        // Straight-line, zero-wait, ending on a halt at 04
        clear_logs();
        run_pulse();
        chk("p1_req_after_run", {31'd0, bus.imem_req}, 32'd1);
        wait_halt("p1_halt");
        chk("p1_exec_count", exec_cyc.size(), 32'd2);
        chk("p1_op0", exec_op[0], 32'h01);
        chk("p1_arg0", exec_arg[0], 32'h11);
        chk("p1_op1", exec_op[1], 32'h02);
        chk("p1_arg1", exec_arg[1], 32'h22);
        chk("p1_period", exec_cyc[1] - exec_cyc[0], 32'd3);
        chk("p1_addr_count", addr_log.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("p1_addr_seq", addr_log[i], i);
        chk("p1_halt_pc", bus.pc, 32'h04);
        chk("p1_halt_req", {31'd0, bus.imem_req}, 32'd0);
        chk("p1_halt_op", bus.op, 32'hff);

        // Resume into two wait-state instructions
        wait_cycles = 2;
        clear_logs();
        run_pulse();
        chk("p2_halted_clr", {31'd0, bus.halted}, 32'd0);
        chk("p2_resume_addr", bus.imem_addr, 32'h06);
        wait_halt("p2_halt");
        chk("p2_exec_count", exec_cyc.size(), 32'd2);
        chk("p2_op0", exec_op[0], 32'h03);
        chk("p2_arg0", exec_arg[0], 32'h33);
        chk("p2_op1", exec_op[1], 32'h04);
        chk("p2_arg1", exec_arg[1], 32'h44);
        chk("p2_period", exec_cyc[1] - exec_cyc[0], 32'd7);
        chk("p2_addr_stable", unstable, 32'd0);
        for (int i = 0; i < 6; i++) chk("p2_addr_seq", addr_log[i], 6 + i);
        chk("p2_halt_pc", bus.pc, 32'h0a);

        // Jump taken, then jump not taken
        wait_cycles  = 0;
        bus.jmp_load = 1'b1;
        bus.jmp_addr = 8'h40;
        run_pulse();
        wait_exec("p3_exec");
        chk("p3_op", bus.op, 32'h09);
        step();
        bus.jmp_load = 1'b0;
        chk("p3_jmp_addr", bus.imem_addr, 32'h40);
        chk("p3_jmp_req", {31'd0, bus.imem_req}, 32'd1);
        wait_halt("p3_halt");
        chk("p3_halt_pc", bus.pc, 32'h40);
        run_pulse();
        chk("p3b_resume_addr", bus.imem_addr, 32'h42);
        wait_exec("p3b_exec");
        step();
        chk("p3b_next_addr", bus.imem_addr, 32'h44);
        wait_halt("p3b_halt");

        // Multi-cycle exec; a jump request outside the done cycle must be ignored
        done_always = 1'b0;
        done_delay  = 3;
        run_pulse();
        wait_exec("p4_exec");
        bus.jmp_load = 1'b1;
        bus.jmp_addr = 8'h80;
        step();
        chk("p4_exec_low", {31'd0, bus.exec}, 32'd0);
        chk("p4_pc_hold1", bus.pc, 32'h46);
        step();
        bus.jmp_load = 1'b0;
        chk("p4_pc_hold2", bus.pc, 32'h46);
        step();
        chk("p4_pc_hold3", bus.pc, 32'h46);
        chk("p4_req_low", {31'd0, bus.imem_req}, 32'd0);
        step();
        chk("p4_pc_next", bus.pc, 32'h48);
        chk("p4_req_next", {31'd0, bus.imem_req}, 32'd1);
        wait_halt("p4_halt");
        chk("p4_exec_width", exec_dbl, 32'd0);

        // Wrap at fe and at ff
        done_always = 1'b1;
        mem[8'h00] = 8'hff; mem[8'h01] = 8'hff; mem[8'h02] = 8'h09; mem[8'h03] = 8'h00;
        bus.jmp_load = 1'b1;
        bus.jmp_addr = 8'hfe;
        run_pulse();
        wait_exec("p5_exec_jmp");
        step();
        bus.jmp_load = 1'b0;
        chk("p5_pc_fe", bus.pc, 32'hfe);
        wait_exec("p5_exec_fe");
        chk("p5_op_fe", bus.op, 32'h06);
        chk("p5_arg_fe", bus.arg, 32'h66);
        step();
        chk("p5_wrap_pc00", bus.pc, 32'h00);
        chk("p5_wrap_addr00", bus.imem_addr, 32'h00);
        wait_halt("p5_halt00");
        bus.jmp_load = 1'b1;
        bus.jmp_addr = 8'hff;
        run_pulse();
        chk("p5_resume_addr02", bus.imem_addr, 32'h02);
        wait_exec("p5_exec_jmp2");
        step();
        bus.jmp_load = 1'b0;
        chk("p5_pc_ff", bus.pc, 32'hff);
        addr_log.delete();
        wait_exec("p5_exec_ff");
        chk("p5_op_ff", bus.op, 32'h66);
        chk("p5_arg_ff", bus.arg, 32'hff);
        chk("p5_ff_fetch_count", addr_log.size(), 32'd2);
        chk("p5_ff_fetch_op", addr_log[0], 32'hff);
        chk("p5_ff_fetch_arg", addr_log[1], 32'h00);
        step();
        chk("p5_wrap_pc01", bus.pc, 32'h01);
        wait_halt("p5_halt01");
        chk("p5_halt_pc01", bus.pc, 32'h01);

        // Reset while F_ARG is waiting on memory
        wait_cycles = 2;
        run_pulse();
        chk("p6_resume_addr", bus.imem_addr, 32'h03);
        for (int i = 0; i < 20; i++) begin
            if ((bus.imem_req === 1'b1) && (bus.imem_addr === 8'h04)) break;
            step();
        end
        chk("p6_in_farg", bus.imem_addr, 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        chk("p6_rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("p6_rst_addr", bus.imem_addr, 32'h00);
        chk("p6_rst_pc", bus.pc, 32'h00);
        chk("p6_rst_op", bus.op, 32'h00);
        chk("p6_rst_arg", bus.arg, 32'h00);
        chk("p6_rst_exec", {31'd0, bus.exec}, 32'd0);
        chk("p6_rst_halted", {31'd0, bus.halted}, 32'd0);
        step();
        step();
        rst_n     = 1'b1;
        ack_force = 1'b1;
        step();
        step();
        ack_force = 1'b0;
        chk("p6_idle_req", {31'd0, bus.imem_req}, 32'd0);
        chk("p6_idle_op", bus.op, 32'h00);
        chk("p6_idle_pc", bus.pc, 32'h00);
        step();
        chk("p6_idle_req2", {31'd0, bus.imem_req}, 32'd0);
        run_pulse();
        chk("p6_run_req", {31'd0, bus.imem_req}, 32'd1);
        chk("p6_run_addr", bus.imem_addr, 32'h00);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/d8_fetch_seq.md
# d8_fetch_seq

Instruction fetch/execute sequencer for the dumb8 core. It owns the program counter and fetches each two-byte instruction (opcode byte, then operand byte) from instruction memory over a req/ack handshake. It presents the instruction to the execute datapath, and on completion either advances the PC or loads the target chosen by the jump handler. It sits between instruction memory, the jump handler (`jmp_load`/`jmp_addr`) and the execute unit.

## Interface
- `RESET_PC`, 8'h00, PC value after reset.
- `HALT_OP`, 8'hff, opcode that stops the sequencer instead of executing.

- `sys_clk`  in  1  system clock; all state on rising edge.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  start from IDLE / resume from HALT (level, sampled).
- `imem_req`  out  1  fetch request; holds until acked.
- `imem_addr`  out  8  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory accepts request; `imem_data` valid same cycle.
- `imem_data`  in  8  fetched byte.
- `op`  out  8  current opcode register.
- `arg`  out  8  current operand register.
- `exec`  out  1  one-cycle pulse: `op`/`arg` valid, execute starts.
- `exec_done`  in  1  execute unit finished current instruction.
- `jmp_load`  in  1  from jump handler: take jump.
- `jmp_addr`  in  8  from jump handler: jump target.
- `pc`  out  8  address of current instruction's opcode byte.
- `halted`  out  1  high while in HALT.

## Operation
- States:
  - IDLE: after reset, waits for `run`.
  - F_OP: fetches the opcode byte.
  - F_ARG: fetches the operand byte.
  - EXEC: instruction handed to the execute unit.
  - HALT: stopped on `HALT_OP`.
- IDLE: `imem_req`=0. `run`=1 → F_OP.
- F_OP:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`: `op`←`imem_data`, → F_ARG.
- F_ARG:
  - `imem_req`=1, `imem_addr`=`pc`+1, mod 256 (pc=8'hff fetches arg from 8'h00).
  - On `imem_ack`: `arg`←`imem_data`.
  - If `op`==`HALT_OP` → HALT; else → EXEC.
- EXEC:
  - `exec` pulses on the first cycle only. `imem_req`=0.
  - Waits for `exec_done`, which may arrive in the pulse cycle itself.
  - On `exec_done`: `pc`←`jmp_addr` if `jmp_load`=1, else `pc`+2 mod 256 (8'hfe→8'h00, 8'hff→8'h01). Then → F_OP.
  - `jmp_load`/`jmp_addr` are sampled only in the `exec_done` cycle and ignored at all other times.
- HALT:
  - `halted`=1, `imem_req`=0, `pc` holds the halt instruction's address.
  - `run`=1 → `pc`←`pc`+2, → F_OP.
- `imem_req`/`imem_addr` are registered state decodes: no combinational path from any input to `imem_req`, `imem_addr` or `exec`.
- `op`/`arg` hold their values until overwritten by the next fetch.
- Reset asserted in any state: all outputs go to reset values immediately, state → IDLE, and any outstanding request is abandoned. A late `imem_ack` after reset release is ignored in IDLE.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `imem_req`=0, `op`=0, `arg`=0, `exec`=0, `halted`=0.
- The F_OP→F_ARG transition keeps `imem_req` high across back-to-back cycles; only the address changes.
- Minimum instruction time is 3 cycles (zero-wait memory, `exec_done` in the pulse cycle): F_OP, F_ARG, EXEC. Each memory wait cycle adds 1, as does each EXEC cycle before `exec_done`.
- The new `pc` is visible the cycle after `exec_done`, together with `imem_req`=1 for the next opcode.
- IDLE/HALT exit: `imem_req` rises the cycle after `run` is sampled high.
- `exec_done` outside EXEC is ignored. `run` outside IDLE/HALT is ignored.

## Test plan
- Straight-line, zero-wait: memory holds 01 11 02 22 at 00..03, `run` pulsed, `exec_done`=1 always.
  - `exec` pulses with op=01,arg=11 then op=02,arg=22, 3 cycles apart.
  - `imem_addr` sequence is 00,01,02,03.
- Wait states: `imem_ack` delayed 2 cycles per fetch.
  - `imem_addr` is stable while `imem_req` is held.
  - Instruction period is 7 cycles; captured bytes are correct.
- Jump: op 09 at pc=04, `jmp_load`=1, `jmp_addr`=40 in the `exec_done` cycle.
  - Next `imem_addr`=40.
  - With `jmp_load`=0 instead, next `imem_addr`=06.
- Multi-cycle exec and wrap:
  - `exec_done` 3 cycles after `exec`: `exec` is high exactly 1 cycle; `pc` is unchanged until done.
  - Instruction at pc=fe: next `pc`=00.
  - Instruction at pc=ff: arg fetched from 00, next `pc`=01.
- Halt: FF at pc=10.
  - No `exec` pulse; `halted`=1; `pc`=10.
  - `run` pulse → `halted`=0, `imem_addr`=12.
- Reset mid-fetch: `sys_rst_n` low while `imem_req`=1 in F_ARG.
  - All outputs drop to reset values asynchronously.
  - After release: IDLE, no request until `run`.
